lfsr_test_sequencer: RTL and testbench

//  Test-run controller for the LFSR generator/checker pair. Loads a seed into both (soft reset),

---
 rtl/lfsr_test_sequencer_if.sv | 30 +++
 rtl/lfsr_test_sequencer.sv | 146 ++++++++++++++
 tb/tb_lfsr_test_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_test_sequencer_if.sv
// Control/status bundle between the LFSR test sequencer and its driver.
// The slave modport is the sequencer's view. The master modport is the controller's view.
interface lfsr_test_sequencer_if;
  logic        i_start;
  logic        i_abort;
  logic [15:0] i_seed;
  logic        i_lock;
  logic        o_soft_reset;
  logic [15:0] o_seed;
  logic        o_valid;
  logic        o_corrupt;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic [1:0]  o_err_code;
  logic [15:0] o_lock_latency;
  logic [2:0]  o_state;

  modport slave (
    input  i_start, i_abort, i_seed, i_lock,
    output o_soft_reset, o_seed, o_valid, o_corrupt, o_busy, o_done,
           o_pass, o_err_code, o_lock_latency, o_state
  );

  modport master (
    output i_start, i_abort, i_seed, i_lock,
    input  o_soft_reset, o_seed, o_valid, o_corrupt, o_busy, o_done,
           o_pass, o_err_code, o_lock_latency, o_state
  );
endinterface

// File: rtl/lfsr_test_sequencer.sv
// Test-run controller for the LFSR generator/checker pair.
// Sequence: seed, acquire lock, hold lock, optionally inject corruption, then report the result.
module lfsr_test_sequencer #(
  parameter int unsigned DEF_SEED       = 300,
  parameter int unsigned LOCK_TIMEOUT   = 64,
  parameter int unsigned RUN_LEN        = 1024,
  parameter int unsigned UNLOCK_TIMEOUT = 16,
  parameter bit          INJECT_EN      = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  lfsr_test_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_RUN     = 3'd3,
    ST_INJECT  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [15:0] DEF_SEED_V  = 16'(DEF_SEED);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] RUN_LAST    = 16'(RUN_LEN - 1);
  localparam logic [15:0] UNLOCK_LAST = 16'(UNLOCK_TIMEOUT - 1);

  state_t      state;
  logic [15:0] phase_cnt;

  assign bus.o_state = state;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state              <= ST_IDLE;
      phase_cnt          <= '0;
      bus.o_soft_reset   <= 1'b0;
      bus.o_seed         <= DEF_SEED_V;
      bus.o_valid        <= 1'b0;
      bus.o_corrupt      <= 1'b0;
      bus.o_busy         <= 1'b0;
      bus.o_done         <= 1'b0;
      bus.o_pass         <= 1'b0;
      bus.o_err_code     <= 2'd0;
      bus.o_lock_latency <= '0;
    end else if (bus.i_abort && state != ST_IDLE) begin
      // Abort overrides any start request or phase transition in the same cycle.
      state              <= ST_IDLE;
      phase_cnt          <= '0;
      bus.o_soft_reset   <= 1'b0;
      bus.o_valid        <= 1'b0;
      bus.o_corrupt      <= 1'b0;
      bus.o_busy         <= 1'b0;
      bus.o_done         <= 1'b0;
      bus.o_pass         <= 1'b0;
      bus.o_err_code     <= 2'd0;
      bus.o_lock_latency <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start) begin
            state              <= ST_SEED;
            phase_cnt          <= '0;
            bus.o_seed         <= (bus.i_seed == 16'd0) ? DEF_SEED_V : bus.i_seed;
            bus.o_soft_reset   <= 1'b1;
            bus.o_valid        <= 1'b0;
            bus.o_busy         <= 1'b1;
            bus.o_done         <= 1'b0;
            bus.o_pass         <= 1'b0;
            bus.o_err_code     <= 2'd0;
            bus.o_lock_latency <= '0;
          end
        end

        ST_SEED: begin
          state            <= ST_ACQUIRE;
          phase_cnt        <= '0;
          bus.o_soft_reset <= 1'b0;
          bus.o_valid      <= 1'b1;
        end

        ST_ACQUIRE: begin
          // Lock takes precedence over a timeout that falls on the same cycle.
          if (bus.i_lock) begin
            state              <= ST_RUN;
            phase_cnt          <= '0;
            bus.o_lock_latency <= phase_cnt;
          end else if (phase_cnt == LOCK_LAST) begin
            state          <= ST_DONE;
            bus.o_valid    <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b1;
            bus.o_pass     <= 1'b0;
            bus.o_err_code <= 2'd1;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end

        ST_RUN: begin
          if (!bus.i_lock) begin
            state          <= ST_DONE;
            bus.o_valid    <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b1;
            bus.o_pass     <= 1'b0;
            bus.o_err_code <= 2'd2;
          end else if (phase_cnt == RUN_LAST) begin
            if (INJECT_EN) begin
              state         <= ST_INJECT;
              phase_cnt     <= '0;
              bus.o_corrupt <= 1'b1;
            end else begin
              state       <= ST_DONE;
              bus.o_valid <= 1'b0;
              bus.o_busy  <= 1'b0;
              bus.o_done  <= 1'b1;
              bus.o_pass  <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end

        ST_INJECT: begin
          // Losing lock under corruption is the expected outcome and wins over the timeout.
          if (!bus.i_lock || phase_cnt == UNLOCK_LAST) begin
            state          <= ST_DONE;
            bus.o_valid    <= 1'b0;
            bus.o_corrupt  <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b1;
            bus.o_pass     <= !bus.i_lock;
            bus.o_err_code <= bus.i_lock ? 2'd3 : 2'd0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_test_sequencer.sv
// Directed bench for lfsr_test_sequencer with a hand-modelled checker lock flag.
// The bench uses a short RUN_LEN so that the whole sequence finishes quickly.
module tb_lfsr_test_sequencer;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;
  int   corruptCycles;

  lfsr_test_sequencer_if bus ();

  lfsr_test_sequencer #(
    .DEF_SEED(300), .LOCK_TIMEOUT(64), .RUN_LEN(32), .UNLOCK_TIMEOUT(16), .INJECT_EN(1'b1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic abort, input logic lock,
                               input logic [15:0] seed, input int cycles);
    bus.i_start = start;
    bus.i_abort = abort;
    bus.i_lock  = lock;
    bus.i_seed  = seed;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b0;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_lock  = 1'b0;
    bus.i_seed  = 16'd0;
    #12;
    checkOutput("reset_state",  32'(bus.o_state), 32'd0);
    checkOutput("reset_seed",   32'(bus.o_seed), 32'd300);
    checkOutput("reset_valid",  32'(bus.o_valid), 32'd0);
    checkOutput("reset_busy",   32'(bus.o_busy), 32'd0);
    checkOutput("reset_done",   32'(bus.o_done), 32'd0);
    checkOutput("reset_softrst", 32'(bus.o_soft_reset), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Nominal run: lock at ACQUIRE cycle 10, unlock at INJECT cycle 3.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h00A5, 1);
    checkOutput("nom_seed_state", 32'(bus.o_state), 32'd1);
    checkOutput("nom_soft_reset", 32'(bus.o_soft_reset), 32'd1);
    checkOutput("nom_seed_value", 32'(bus.o_seed), 32'h00A5);
    checkOutput("nom_seed_busy",  32'(bus.o_busy), 32'd1);
    checkOutput("nom_seed_valid", 32'(bus.o_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'hFFFF, 1);
    checkOutput("nom_acq_state",  32'(bus.o_state), 32'd2);
    checkOutput("nom_acq_softrst", 32'(bus.o_soft_reset), 32'd0);
    checkOutput("nom_acq_valid",  32'(bus.o_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'hFFFF, 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 1);
    checkOutput("nom_run_state",  32'(bus.o_state), 32'd3);
    checkOutput("nom_latency",    32'(bus.o_lock_latency), 32'd10);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 31);
    checkOutput("nom_run_last",   32'(bus.o_state), 32'd3);
    checkOutput("nom_seed_hold",  32'(bus.o_seed), 32'h00A5);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 1);
    checkOutput("nom_inj_state",  32'(bus.o_state), 32'd4);
    checkOutput("nom_inj_corrupt", 32'(bus.o_corrupt), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'hFFFF, 1);
    checkOutput("nom_done_state", 32'(bus.o_state), 32'd5);
    checkOutput("nom_done",       32'(bus.o_done), 32'd1);
    checkOutput("nom_pass",       32'(bus.o_pass), 32'd1);
    checkOutput("nom_err",        32'(bus.o_err_code), 32'd0);
    checkOutput("nom_done_busy",  32'(bus.o_busy), 32'd0);
    checkOutput("nom_done_corrupt", 32'(bus.o_corrupt), 32'd0);

    // No lock: the timeout fires on ACQUIRE cycle 63.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 1);
    checkOutput("nolock_clear_done", 32'(bus.o_done), 32'd0);
    checkOutput("nolock_clear_lat",  32'(bus.o_lock_latency), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 63);
    checkOutput("nolock_last_acq", 32'(bus.o_state), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 1);
    checkOutput("nolock_state", 32'(bus.o_state), 32'd5);
    checkOutput("nolock_pass",  32'(bus.o_pass), 32'd0);
    checkOutput("nolock_err",   32'(bus.o_err_code), 32'd1);

    // Zero seed selects the default, then lock at cycle 5 and drop at RUN cycle 20.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1);
    checkOutput("zero_seed_value", 32'(bus.o_seed), 32'd300);
    checkOutput("zero_seed_err",   32'(bus.o_err_code), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1);
    checkOutput("drop_latency", 32'(bus.o_lock_latency), 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 20);
    checkOutput("drop_run", 32'(bus.o_state), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1);
    checkOutput("drop_state", 32'(bus.o_state), 32'd5);
    checkOutput("drop_err",   32'(bus.o_err_code), 32'd2);
    checkOutput("drop_pass",  32'(bus.o_pass), 32'd0);

    // Stuck lock: INJECT times out after 16 corrupted cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0042, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0042, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0042, 1);
    checkOutput("stuck_latency", 32'(bus.o_lock_latency), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0042, 32);
    corruptCycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_corrupt) corruptCycles++;
      tick();
    end
    checkOutput("stuck_corrupt_cycles", 32'(corruptCycles), 32'd16);
    checkOutput("stuck_state", 32'(bus.o_state), 32'd5);
    checkOutput("stuck_err",   32'(bus.o_err_code), 32'd3);
    checkOutput("stuck_pass",  32'(bus.o_pass), 32'd0);

    // Abort at RUN cycle 7.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0077, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0077, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0077, 7);
    checkOutput("abort_pre_state", 32'(bus.o_state), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0077, 1);
    checkOutput("abort_state", 32'(bus.o_state), 32'd0);
    checkOutput("abort_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("abort_done",  32'(bus.o_done), 32'd0);
    checkOutput("abort_busy",  32'(bus.o_busy), 32'd0);
    checkOutput("abort_lat",   32'(bus.o_lock_latency), 32'd0);

    // Asynchronous reset while in ACQUIRE.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0099, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0099, 1);
    checkOutput("arst_pre_state", 32'(bus.o_state), 32'd2);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_state", 32'(bus.o_state), 32'd0);
    checkOutput("arst_seed",  32'(bus.o_seed), 32'd300);
    checkOutput("arst_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("arst_busy",  32'(bus.o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reach DONE quickly, then start and abort together.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0011, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0011, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0011, 1);
    checkOutput("sa_pre_state", 32'(bus.o_state), 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0011, 1);
    checkOutput("sa_state", 32'(bus.o_state), 32'd0);
    checkOutput("sa_done",  32'(bus.o_done), 32'd0);
    checkOutput("sa_err",   32'(bus.o_err_code), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0011, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
